// File: rtl/mem_fill_arbiter.sv
// Arbitrates single-ported pipelined main memory between I-cache fills, D-cache
// fills and D-side write-through stores; sequences in-order block fills.
module mem_fill_arbiter #(
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = 8,
   parameter int IDX_W       = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_miss,
   input  logic [15:0]      i_addr,
   input  logic             d_miss,
   input  logic [15:0]      d_addr,
   input  logic             d_wr_req,
   input  logic [15:0]      d_wr_addr,
   input  logic [15:0]      d_wr_data,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_rvalid,
   output logic [15:0]      fill_data,
   output logic [IDX_W-1:0] fill_word,
   output logic             i_fill_we,
   output logic             d_fill_we,
   output logic             i_fill_done,
   output logic             d_fill_done,
   output logic             d_wr_ack,
   output logic             busy
);

   // state    | meaning
   // S_IDLE   | waiting for a request; grant by priority store > D miss > I miss
   // S_WRITE  | single-cycle store issue with ack
   // S_FILL_I | issuing reads / collecting returns for an I-cache block
   // S_FILL_D | issuing reads / collecting returns for a D-cache block
   // S_DONE_I | one-cycle I fill complete pulse
   // S_DONE_D | one-cycle D fill complete pulse

   if (LATENCY < 1 || BLOCK_WORDS != (1 << IDX_W)) begin : g_param_check
      $error("mem_fill_arbiter: inconsistent LATENCY/BLOCK_WORDS/IDX_W");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_FILL_I, S_FILL_D, S_DONE_I, S_DONE_D
   } state_t;

   localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(BLOCK_WORDS - 1);

   state_t           state_q, state_d;
   logic [15:0]      addr_q, addr_d;
   logic [15:0]      wdata_q, wdata_d;
   logic [IDX_W:0]   iss_cnt_q, iss_cnt_d;
   logic [IDX_W:0]   rcv_cnt_q, rcv_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         iss_cnt_q <= '0;
         rcv_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         iss_cnt_q <= iss_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      iss_cnt_d   = iss_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_data   = mem_rdata;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      busy        = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            iss_cnt_d = '0;
            rcv_cnt_d = '0;
            if (d_wr_req) begin
               state_d = S_WRITE;
               addr_d  = d_wr_addr;
               wdata_d = d_wr_data;
            end else if (d_miss) begin
               state_d = S_FILL_D;
               addr_d  = d_addr;
            end else if (i_miss) begin
               state_d = S_FILL_I;
               addr_d  = i_addr;
            end
         end
         S_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            d_wr_ack  = 1'b1;
            state_d   = S_IDLE;
         end
         S_FILL_I, S_FILL_D: begin
            // The top counter bit marks that every word of the block has been issued.
            if (!iss_cnt_q[IDX_W]) begin
               mem_en    = 1'b1;
               mem_addr  = {addr_q[15:IDX_W+1], iss_cnt_q[IDX_W-1:0], 1'b0};
               iss_cnt_d = iss_cnt_q + CNT_ONE;
            end
            if (mem_rvalid) begin
               fill_word = rcv_cnt_q[IDX_W-1:0];
               i_fill_we = (state_q == S_FILL_I);
               d_fill_we = (state_q == S_FILL_D);
               rcv_cnt_d = rcv_cnt_q + CNT_ONE;
               if (rcv_cnt_q == CNT_LAST)
                  state_d = (state_q == S_FILL_I) ? S_DONE_I : S_DONE_D;
            end
         end
         S_DONE_I: begin
            i_fill_done = 1'b1;
            iss_cnt_d   = '0;
            rcv_cnt_d   = '0;
            state_d     = S_IDLE;
         end
         S_DONE_D: begin
            d_fill_done = 1'b1;
            iss_cnt_d   = '0;
            rcv_cnt_d   = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single-ported, pipelined main memory between three requesters: the I-cache miss path, the D-cache miss path and D-side write-through stores.
- Sequences block fills of BLOCK_WORDS words, issuing one address per cycle and steering returned words to the requesting cache with a word index.
- Sits between both caches and main memory. Fetch and memory stages stall while their cache reports a miss.

Parameters:
- LATENCY, 4, main-memory read latency in cycles: mem_en issue to mem_data_valid.
- BLOCK_WORDS, 8, 16-bit words per cache block; power of 2. Block = BLOCK_WORDS*2 bytes.
- IDX_W, 3, log2(BLOCK_WORDS); width of word counters and fill_word.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_miss  in  1  I-cache miss request; held until i_fill_done.
- i_addr  in  16  I-cache miss byte address.
- d_miss  in  1  D-cache miss request; held until d_fill_done.
- d_addr  in  16  D-cache miss byte address.
- d_wr_req  in  1  write-through store request; held until d_wr_ack.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  mem_rdata valid; asserted LATENCY cycles after each read strobe.
- fill_data  out  16  word being written into a cache; equals mem_rdata.
- fill_word  out  IDX_W  index of fill_data within the block.
- i_fill_we  out  1  write fill_data into the I-cache data array.
- d_fill_we  out  1  write fill_data into the D-cache data array.
- i_fill_done  out  1  one-cycle pulse: I block complete; the I-cache validates its tag.
- d_fill_done  out  1  one-cycle pulse: D block complete.
- d_wr_ack  out  1  one-cycle pulse: store issued to memory.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all counters and latches 0; every output 0. Main memory shares rst, so no read is in flight after reset.
- States: IDLE, WRITE, FILL_I, FILL_D, DONE_I, DONE_D. All outputs decode combinationally from registered state, counters and latches. fill_data passes mem_rdata straight through.
- IDLE grant priority, sampled at the clock edge:
  - d_wr_req -> WRITE.
  - else d_miss -> FILL_D.
  - else i_miss -> FILL_I.
  - Grant latches the address: block base = addr[15:IDX_W+1], plus store data for WRITE. Requester address changes after grant are ignored.
- WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latches, d_wr_ack=1; next state IDLE.
- FILL_x, issue side:
  - iss_cnt runs 0..BLOCK_WORDS-1. While iss_cnt has not wrapped, mem_en=1, mem_wr=0, mem_addr = {base, iss_cnt, 1'b0}.
  - One word per cycle, starting the cycle after grant. Words are always fetched 0..7 in order, never critical-word-first.
- FILL_x, return side:
  - Each mem_rvalid drives x_fill_we=1 with fill_word = rcv_cnt, then increments rcv_cnt.
  - When rvalid arrives with rcv_cnt = BLOCK_WORDS-1, the next state is DONE_x.
- DONE_x (1 cycle): x_fill_done=1; counters cleared; next state IDLE. The requester must drop its miss by the following edge. If the miss is still high in IDLE, a new fill starts.
- Boundary cases:
  - Miss deasserted mid-fill: the fill runs to completion.
  - d_wr_req during a fill or DONE: waits, with no ack, until IDLE.
  - Simultaneous requests: priority order above.
  - mem_rvalid in IDLE or WRITE: ignored; no fill_we.
  - Counters are IDX_W+1 bits so the wrap is detectable.
  - rst low mid-fill: immediately IDLE; no done pulse; partial block not validated.
- Latency, LATENCY=4, grant at edge 0: reads issue in cycles 1..8; data returns in cycles 5..12; done in cycle 13; busy in cycles 1..13. A store occupies exactly 1 cycle after grant.

Test Plan:
- Reset: rst=0 with i_miss=1 -> all outputs 0. Release -> FILL_I. mem_addr for i_addr=0x1236 runs 0x1230..0x123E in cycles 1..8. Memory returns k*0x11 -> i_fill_we cycles 5..12 with fill_word 0..7. i_fill_done in cycle 13 only.
- Simultaneous i_miss and d_miss (d_addr=0x4008) -> D served first at 0x4000..0x400E with d_fill_done; I fill starts the cycle after DONE_D. i_fill_we never asserted during the D fill.
- d_wr_req (0x2002, 0xBEEF) with d_miss -> cycle 1: mem_en=1, mem_wr=1, addr 0x2002, data 0xBEEF, d_wr_ack=1. D fill begins cycle 2.
- d_wr_req raised in cycle 3 of an I fill -> no ack until DONE_I passes; WRITE follows in the cycle after IDLE re-entry.
- Stray mem_rvalid in IDLE -> no fill_we. i_miss dropped in cycle 4 of a fill -> all 8 words still written and the done pulse issued.
- rst pulsed low in cycle 7 of a D fill -> outputs 0 immediately. No d_fill_done. Re-raised d_miss restarts at fill_word 0.
